uni_arbiter: RTL and testbench

//  Two-master / one-slave arbiter for the unified memory request interface (valid/ready/reqtyp/addr/wdata/size/rdata).
//  M0 = IFU fetch port, M1 = LSU load/store port; S = shared memory/AXI bridge port.

---
 rtl/uni_pkg.sv | 18 +
 rtl/uni_arb_pick.sv | 18 +
 rtl/uni_arbiter.sv | 146 ++++++++++++++
 tb/tb_uni_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uni_pkg.sv
// Shared types and encodings for the unified memory request interface.
package uni_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

endpackage

// File: rtl/uni_arb_pick.sv
// Combinational two-way winner select for the unified-interface arbiter.
module uni_arb_pick #(
    parameter bit M1_PRIO = 1'b1
) (
    input  logic m0_valid,
    input  logic m1_valid,
    input  logic last_grant,
    output logic pick_valid,
    output logic pick_m1
);

    // On a tie M1 wins when prioritised, otherwise whoever was not granted last.
    always_comb begin
        pick_valid = m0_valid | m1_valid;
        pick_m1    = m1_valid & (~m0_valid | M1_PRIO | ~last_grant);
    end

endmodule

// File: rtl/uni_arbiter.sv
// Two-master / one-slave arbiter: IFU (M0) and LSU (M1) share one memory port,
// one transaction at a time, with a sticky hung-slave timeout flag.
module uni_arbiter
    import uni_pkg::*;
#(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int M1_PRIO = 1,
    parameter int TMO_CYC = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_m0_valid,
    output logic          o_m0_ready,
    input  logic          i_m0_reqtyp,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    input  logic [1:0]    i_m0_size,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_valid,
    output logic          o_m1_ready,
    input  logic          i_m1_reqtyp,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    input  logic [1:0]    i_m1_size,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_s_valid,
    input  logic          i_s_ready,
    output logic          o_s_reqtyp,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_wdata,
    output logic [1:0]    o_s_size,
    input  logic [DW-1:0] i_s_rdata,
    output logic          o_owner,
    output logic          o_busy,
    output logic          o_tmo_err
);

    localparam int            CW      = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = (TMO_CYC > 0) ? CW'(TMO_CYC - 1) : '0;
    localparam bit            TMO_EN  = (TMO_CYC > 0);

    arb_state_e    state;
    arb_state_e    state_nxt;
    logic          last_grant;
    logic          owner;
    logic          tmo_err;
    logic [CW-1:0] tmo_cnt;
    logic          pick_valid;
    logic          pick_m1;
    logic          enter_gnt;
    logic          done;
    logic          stall;

    uni_arb_pick #(
        .M1_PRIO (M1_PRIO != 0)
    ) u_pick (
        .m0_valid   (i_m0_valid),
        .m1_valid   (i_m1_valid),
        .last_grant (last_grant),
        .pick_valid (pick_valid),
        .pick_m1    (pick_m1)
    );

    always_comb begin
        enter_gnt = (state == ARB_IDLE) && pick_valid;
        done      = (state != ARB_IDLE) && i_s_ready;
        stall     = (state != ARB_IDLE) && !i_s_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    // Every completion drops back to IDLE, giving a one-cycle bubble before the next grant.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (pick_valid) state_nxt = pick_m1 ? ARB_GNT1 : ARB_GNT0;
            ARB_GNT0: if (i_s_ready)  state_nxt = ARB_IDLE;
            ARB_GNT1: if (i_s_ready)  state_nxt = ARB_IDLE;
            default:                  state_nxt = ARB_IDLE;
        endcase
    end

    // Reset value 1 lets M0 win the first round-robin tie.
    always_ff @(posedge i_clk) begin
        if (i_rst)     last_grant <= 1'b1;
        else if (done) last_grant <= (state == ARB_GNT1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)          owner <= 1'b0;
        else if (enter_gnt) owner <= pick_m1;
    end

    // Counter saturates at the trip point so a long hang never wraps back to quiet.
    always_ff @(posedge i_clk) begin
        if (i_rst)                            tmo_cnt <= '0;
        else if (enter_gnt)                   tmo_cnt <= '0;
        else if (stall && tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)                                    tmo_err <= 1'b0;
        else if (TMO_EN && stall && tmo_cnt == CNT_MAX) tmo_err <= 1'b1;
    end

    always_comb begin
        o_s_valid  = 1'b0;
        o_s_reqtyp = REQ_RD;
        o_s_addr   = '0;
        o_s_wdata  = '0;
        o_s_size   = SZ_B;
        o_m0_ready = 1'b0;
        o_m1_ready = 1'b0;
        o_m0_rdata = '0;
        o_m1_rdata = '0;
        o_busy     = (state != ARB_IDLE);
        o_owner    = owner;
        o_tmo_err  = tmo_err;
        case (state)
            ARB_GNT0: begin
                o_s_valid  = 1'b1;
                o_s_reqtyp = i_m0_reqtyp;
                o_s_addr   = i_m0_addr;
                o_s_wdata  = i_m0_wdata;
                o_s_size   = i_m0_size;
                o_m0_ready = i_s_ready;
                o_m0_rdata = i_s_rdata;
            end
            ARB_GNT1: begin
                o_s_valid  = 1'b1;
                o_s_reqtyp = i_m1_reqtyp;
                o_s_addr   = i_m1_addr;
                o_s_wdata  = i_m1_wdata;
                o_s_size   = i_m1_size;
                o_m1_ready = i_s_ready;
                o_m1_rdata = i_s_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uni_arbiter.sv
// Scoreboard bench for uni_arbiter: a priority instance and a round-robin
// instance share one stimulus; each scenario task checks the relevant one.
module tb_uni_arbiter;
    import uni_pkg::*;

    typedef struct {
        logic        owner;
        logic [63:0] addr;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_m0_valid = 1'b0, i_m0_reqtyp = 1'b0;
    logic [63:0] i_m0_addr = '0, i_m0_wdata = '0;
    logic [1:0]  i_m0_size = '0;
    logic        i_m1_valid = 1'b0, i_m1_reqtyp = 1'b0;
    logic [63:0] i_m1_addr = '0, i_m1_wdata = '0;
    logic [1:0]  i_m1_size = '0;
    logic        i_s_ready = 1'b0;
    logic [63:0] i_s_rdata = '0;
    logic        use_rr = 1'b0;

    logic        p_m0_ready, p_m1_ready, p_s_valid, p_s_reqtyp, p_owner, p_busy, p_tmo;
    logic [63:0] p_m0_rdata, p_m1_rdata, p_s_addr, p_s_wdata;
    logic [1:0]  p_s_size;
    logic        r_m0_ready, r_m1_ready, r_s_valid, r_s_reqtyp, r_owner, r_busy, r_tmo;
    logic [63:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
    logic [1:0]  r_s_size;

    logic        obs_m0_ready, obs_m1_ready, obs_s_valid, obs_s_reqtyp, obs_owner, obs_busy, obs_tmo;
    logic [63:0] obs_m0_rdata, obs_m1_rdata, obs_s_addr, obs_s_wdata;
    logic [1:0]  obs_s_size;

    assign obs_m0_ready = use_rr ? r_m0_ready : p_m0_ready;
    assign obs_m1_ready = use_rr ? r_m1_ready : p_m1_ready;
    assign obs_s_valid  = use_rr ? r_s_valid  : p_s_valid;
    assign obs_s_reqtyp = use_rr ? r_s_reqtyp : p_s_reqtyp;
    assign obs_owner    = use_rr ? r_owner    : p_owner;
    assign obs_busy     = use_rr ? r_busy     : p_busy;
    assign obs_tmo      = use_rr ? r_tmo      : p_tmo;
    assign obs_m0_rdata = use_rr ? r_m0_rdata : p_m0_rdata;
    assign obs_m1_rdata = use_rr ? r_m1_rdata : p_m1_rdata;
    assign obs_s_addr   = use_rr ? r_s_addr   : p_s_addr;
    assign obs_s_wdata  = use_rr ? r_s_wdata  : p_s_wdata;
    assign obs_s_size   = use_rr ? r_s_size   : p_s_size;

    always #5 i_clk = ~i_clk;

    uni_arbiter #(.AW(64), .DW(64), .M1_PRIO(1), .TMO_CYC(8)) dut_p (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_valid(i_m0_valid), .o_m0_ready(p_m0_ready), .i_m0_reqtyp(i_m0_reqtyp),
        .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata), .i_m0_size(i_m0_size), .o_m0_rdata(p_m0_rdata),
        .i_m1_valid(i_m1_valid), .o_m1_ready(p_m1_ready), .i_m1_reqtyp(i_m1_reqtyp),
        .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata), .i_m1_size(i_m1_size), .o_m1_rdata(p_m1_rdata),
        .o_s_valid(p_s_valid), .i_s_ready(i_s_ready), .o_s_reqtyp(p_s_reqtyp), .o_s_addr(p_s_addr),
        .o_s_wdata(p_s_wdata), .o_s_size(p_s_size), .i_s_rdata(i_s_rdata),
        .o_owner(p_owner), .o_busy(p_busy), .o_tmo_err(p_tmo)
    );

    uni_arbiter #(.AW(64), .DW(64), .M1_PRIO(0), .TMO_CYC(8)) dut_rr (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_valid(i_m0_valid), .o_m0_ready(r_m0_ready), .i_m0_reqtyp(i_m0_reqtyp),
        .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata), .i_m0_size(i_m0_size), .o_m0_rdata(r_m0_rdata),
        .i_m1_valid(i_m1_valid), .o_m1_ready(r_m1_ready), .i_m1_reqtyp(i_m1_reqtyp),
        .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata), .i_m1_size(i_m1_size), .o_m1_rdata(r_m1_rdata),
        .o_s_valid(r_s_valid), .i_s_ready(i_s_ready), .o_s_reqtyp(r_s_reqtyp), .o_s_addr(r_s_addr),
        .o_s_wdata(r_s_wdata), .o_s_size(r_s_size), .i_s_rdata(i_s_rdata),
        .o_owner(r_owner), .o_busy(r_busy), .o_tmo_err(r_tmo)
    );

    // Leaves the bench at posedge+2 with both instances in IDLE.
    task automatic reset_dut();
        @(posedge i_clk); #2;
        i_rst = 1'b1; i_m0_valid = 1'b0; i_m1_valid = 1'b0; i_s_ready = 1'b0;
        repeat (2) begin @(posedge i_clk); #2; end
        i_rst = 1'b0;
    endtask

    // Slave model: answers the current grant after wait_cyc GNT cycles and reports what it saw.
    task automatic do_txn(input int wait_cyc, input logic [63:0] rd,
                          output int gc, output int ic, output int p0, output int p1,
                          output logic ow, output logic [63:0] ad, output logic ty,
                          output logic [63:0] wd, output logic [1:0] sz,
                          output logic [63:0] r0, output logic [63:0] r1, output bit expired);
        bit fin = 1'b0;
        gc = 0; ic = 0; p0 = 0; p1 = 0; expired = 1'b1;
        ow = 1'b0; ad = '0; ty = 1'b0; wd = '0; sz = '0; r0 = '0; r1 = '0;
        for (int c = 0; c < 64 && !fin; c++) begin
            if (obs_s_valid) gc++;
            else if (gc == 0) ic++;
            i_s_ready = obs_s_valid && (gc == wait_cyc);
            i_s_rdata = rd;
            #2;
            if (obs_m0_ready) p0++;
            if (obs_m1_ready) p1++;
            if (i_s_ready) begin
                ow = obs_owner; ad = obs_s_addr; ty = obs_s_reqtyp; wd = obs_s_wdata;
                sz = obs_s_size; r0 = obs_m0_rdata; r1 = obs_m1_rdata;
                expired = 1'b0; fin = 1'b1;
            end
            @(posedge i_clk); #2;
            i_s_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(posedge i_clk); #2;
        i_rst = 1'b1; i_m0_valid = 1'b1; i_m1_valid = 1'b1;
        i_m0_addr = 64'h1234; i_m1_addr = 64'h5678; i_m1_wdata = 64'hFFFF; i_m1_size = 2'b11; i_m1_reqtyp = 1'b1;
        i_s_ready = 1'b1; i_s_rdata = 64'h5A5A;
        repeat (2) begin @(posedge i_clk); #2; end
        i_rst = 1'b0; i_m0_valid = 1'b0; i_m1_valid = 1'b0;
        #2;
        n_cmp++; if (obs_s_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_s_valid got %b want 0", obs_s_valid); end
        n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy got %b want 0", obs_busy); end
        n_cmp++; if (obs_owner !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_owner got %b want 0", obs_owner); end
        n_cmp++; if (obs_tmo !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_tmo got %b want 0", obs_tmo); end
        n_cmp++; if ({obs_m0_ready, obs_m1_ready} !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_ready got %b%b want 00", obs_m0_ready, obs_m1_ready); end
        n_cmp++; if ((obs_m0_rdata | obs_m1_rdata) !== 64'h0) begin n_bad++; $display("[TB] FAIL rst_rdata got %h/%h want 0", obs_m0_rdata, obs_m1_rdata); end
        n_cmp++; if (obs_s_addr !== 64'h0) begin n_bad++; $display("[TB] FAIL rst_s_addr got %h want 0", obs_s_addr); end
        n_cmp++; if ({obs_s_wdata, obs_s_size, obs_s_reqtyp} !== 67'h0) begin n_bad++; $display("[TB] FAIL rst_s_fields got %h %b %b want 0", obs_s_wdata, obs_s_size, obs_s_reqtyp); end
        i_s_ready = 1'b0;
        i_m1_wdata = '0; i_m1_size = '0; i_m1_reqtyp = 1'b0;
    endtask

    task automatic test_m0_read();
        int gc, ic, p0, p1; logic ow, ty; logic [63:0] ad, wd, r0, r1; logic [1:0] sz; bit ex; exp_t e;
        reset_dut(); use_rr = 1'b0;
        i_m0_valid = 1'b1; i_m0_reqtyp = REQ_RD; i_m0_addr = 64'h8000_0000; i_m0_size = SZ_W;
        e.owner = 1'b0; e.addr = 64'h8000_0000; e.rdata = 64'h13; sb.push_back(e);
        do_txn(3, 64'h13, gc, ic, p0, p1, ow, ad, ty, wd, sz, r0, r1, ex);
        n_cmp++; if (ex !== 1'b0) begin n_bad++; $display("[TB] FAIL t1_expired got %b want 0", ex); end
        n_cmp++; if (gc !== 3) begin n_bad++; $display("[TB] FAIL t1_s_valid_cycles got %0d want 3", gc); end
        n_cmp++; if (ic !== 1) begin n_bad++; $display("[TB] FAIL t1_latency got %0d want 1", ic); end
        n_cmp++; if (p0 !== 1 || p1 !== 0) begin n_bad++; $display("[TB] FAIL t1_pulses got %0d/%0d want 1/0", p0, p1); end
        n_cmp++; if (r1 !== 64'h0) begin n_bad++; $display("[TB] FAIL t1_m1_rdata got %h want 0", r1); end
        n_cmp++; if (sb.size() == 0) begin n_bad++; $display("[TB] FAIL t1_sb got empty want entry"); end
        else begin
            e = sb.pop_front();
            n_cmp++; if (ow !== e.owner) begin n_bad++; $display("[TB] FAIL t1_owner got %b want %b", ow, e.owner); end
            n_cmp++; if (ad !== e.addr) begin n_bad++; $display("[TB] FAIL t1_addr got %h want %h", ad, e.addr); end
            n_cmp++; if (r0 !== e.rdata) begin n_bad++; $display("[TB] FAIL t1_rdata got %h want %h", r0, e.rdata); end
        end
        n_cmp++; if (obs_s_valid !== 1'b0 || obs_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL t1_idle got %b%b want 00", obs_s_valid, obs_busy); end
        i_m0_valid = 1'b0;
    endtask

    task automatic test_priority();
        int gc, ic, p0, p1; logic ow, ty; logic [63:0] ad, wd, r0, r1; logic [1:0] sz; bit ex; exp_t e;
        reset_dut(); use_rr = 1'b0;
        i_m0_valid = 1'b1; i_m0_addr = 64'hA000; i_m1_valid = 1'b1; i_m1_addr = 64'hB000;
        e.owner = 1'b1; e.addr = 64'hB000; e.rdata = 64'h21; sb.push_back(e);
        e.owner = 1'b0; e.addr = 64'hA000; e.rdata = 64'h22; sb.push_back(e);
        for (int t = 0; t < 2; t++) begin
            do_txn(t + 1, (t == 0) ? 64'h21 : 64'h22, gc, ic, p0, p1, ow, ad, ty, wd, sz, r0, r1, ex);
            if (t == 0) i_m1_valid = 1'b0;
            n_cmp++; if (ex !== 1'b0 || ic !== 1) begin n_bad++; $display("[TB] FAIL t2_gap%0d got exp=%b idle=%0d want 0/1", t, ex, ic); end
            n_cmp++; if (sb.size() == 0) begin n_bad++; $display("[TB] FAIL t2_sb got empty want entry"); end
            else begin
                e = sb.pop_front();
                n_cmp++; if (ow !== e.owner) begin n_bad++; $display("[TB] FAIL t2_owner%0d got %b want %b", t, ow, e.owner); end
                n_cmp++; if (ad !== e.addr) begin n_bad++; $display("[TB] FAIL t2_addr%0d got %h want %h", t, ad, e.addr); end
                n_cmp++; if ((e.owner ? r1 : r0) !== e.rdata) begin n_bad++; $display("[TB] FAIL t2_rdata%0d got %h want %h", t, e.owner ? r1 : r0, e.rdata); end
                n_cmp++; if ((e.owner ? p1 : p0) !== 1 || (e.owner ? p0 : p1) !== 0) begin n_bad++; $display("[TB] FAIL t2_pulses%0d got %0d/%0d", t, p0, p1); end
            end
        end
        i_m0_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        int gc, ic, p0, p1; logic ow, ty; logic [63:0] ad, wd, r0, r1; logic [1:0] sz; bit ex; exp_t e;
        reset_dut(); use_rr = 1'b1;
        i_m0_valid = 1'b1; i_m0_addr = 64'hA0; i_m1_valid = 1'b1; i_m1_addr = 64'hB0;
        for (int t = 0; t < 6; t++) begin
            e.owner = t[0]; e.addr = t[0] ? 64'hB0 : 64'hA0; e.rdata = 64'h100 + 64'(t);
            sb.push_back(e);
        end
        for (int t = 0; t < 6; t++) begin
            do_txn(1, 64'h100 + 64'(t), gc, ic, p0, p1, ow, ad, ty, wd, sz, r0, r1, ex);
            n_cmp++; if (ex !== 1'b0 || ic !== 1) begin n_bad++; $display("[TB] FAIL t3_gap%0d got exp=%b idle=%0d want 0/1", t, ex, ic); end
            n_cmp++; if (sb.size() == 0) begin n_bad++; $display("[TB] FAIL t3_sb got empty want entry"); end
            else begin
                e = sb.pop_front();
                n_cmp++; if (ow !== e.owner) begin n_bad++; $display("[TB] FAIL t3_owner%0d got %b want %b", t, ow, e.owner); end
                n_cmp++; if (ad !== e.addr) begin n_bad++; $display("[TB] FAIL t3_addr%0d got %h want %h", t, ad, e.addr); end
                n_cmp++; if ((e.owner ? r1 : r0) !== e.rdata) begin n_bad++; $display("[TB] FAIL t3_rdata%0d got %h want %h", t, e.owner ? r1 : r0, e.rdata); end
            end
        end
        i_m0_valid = 1'b0; i_m1_valid = 1'b0;
        use_rr = 1'b0;
    endtask

    task automatic test_m1_write();
        int gc, ic, p0, p1; logic ow, ty; logic [63:0] ad, wd, r0, r1; logic [1:0] sz; bit ex; exp_t e;
        reset_dut(); use_rr = 1'b0;
        i_m1_valid = 1'b1; i_m1_reqtyp = REQ_WR; i_m1_addr = 64'h1000_0000;
        i_m1_wdata = 64'hDEAD_BEEF; i_m1_size = SZ_D;
        e.owner = 1'b1; e.addr = 64'h1000_0000; e.rdata = 64'h55; sb.push_back(e);
        @(posedge i_clk); #2;
        i_m0_valid = 1'b1; i_m0_reqtyp = REQ_RD; i_m0_addr = 64'h4440; i_m0_size = SZ_H;
        e.owner = 1'b0; e.addr = 64'h4440; e.rdata = 64'h77; sb.push_back(e);
        do_txn(3, 64'h55, gc, ic, p0, p1, ow, ad, ty, wd, sz, r0, r1, ex);
        i_m1_valid = 1'b0;
        n_cmp++; if (ex !== 1'b0 || gc !== 3) begin n_bad++; $display("[TB] FAIL t4_gnt got exp=%b cycles=%0d want 0/3", ex, gc); end
        n_cmp++; if (ty !== 1'b1 || sz !== 2'b11) begin n_bad++; $display("[TB] FAIL t4_typ_size got %b/%b want 1/11", ty, sz); end
        n_cmp++; if (wd !== 64'hDEAD_BEEF) begin n_bad++; $display("[TB] FAIL t4_wdata got %h want deadbeef", wd); end
        n_cmp++; if (p0 !== 0 || p1 !== 1) begin n_bad++; $display("[TB] FAIL t4_pulses got %0d/%0d want 0/1", p0, p1); end
        for (int t = 0; t < 2; t++) begin
            if (t == 1) do_txn(1, 64'h77, gc, ic, p0, p1, ow, ad, ty, wd, sz, r0, r1, ex);
            n_cmp++; if (sb.size() == 0) begin n_bad++; $display("[TB] FAIL t4_sb got empty want entry"); end
            else begin
                e = sb.pop_front();
                n_cmp++; if (ow !== e.owner) begin n_bad++; $display("[TB] FAIL t4_owner%0d got %b want %b", t, ow, e.owner); end
                n_cmp++; if (ad !== e.addr) begin n_bad++; $display("[TB] FAIL t4_addr%0d got %h want %h", t, ad, e.addr); end
                n_cmp++; if ((e.owner ? r1 : r0) !== e.rdata) begin n_bad++; $display("[TB] FAIL t4_rdata%0d got %h want %h", t, e.owner ? r1 : r0, e.rdata); end
            end
        end
        n_cmp++; if (ic !== 1 || ex !== 1'b0) begin n_bad++; $display("[TB] FAIL t4_m0_gap got idle=%0d exp=%b want 1/0", ic, ex); end
        i_m0_valid = 1'b0; i_m1_reqtyp = 1'b0; i_m1_wdata = '0; i_m1_size = '0;
    endtask

    task automatic test_timeout();
        reset_dut(); use_rr = 1'b0;
        i_m0_valid = 1'b1; i_m0_addr = 64'h2000; i_s_rdata = 64'h99;
        @(posedge i_clk); #2;
        for (int k = 1; k <= 12; k++) begin
            i_s_ready = 1'b0; #2;
            n_cmp++; if (obs_tmo !== (k >= 9)) begin n_bad++; $display("[TB] FAIL t5_tmo_c%0d got %b want %b", k, obs_tmo, k >= 9); end
            n_cmp++; if (obs_s_valid !== 1'b1 || obs_m0_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL t5_hold_c%0d got %b%b want 10", k, obs_s_valid, obs_m0_ready); end
            @(posedge i_clk); #2;
        end
        i_s_ready = 1'b1; #2;
        n_cmp++; if (obs_m0_ready !== 1'b1 || obs_m0_rdata !== 64'h99) begin n_bad++; $display("[TB] FAIL t5_late_ready got %b %h want 1 99", obs_m0_ready, obs_m0_rdata); end
        @(posedge i_clk); #2;
        i_s_ready = 1'b0; i_m0_valid = 1'b0; #2;
        n_cmp++; if (obs_s_valid !== 1'b0 || obs_tmo !== 1'b1) begin n_bad++; $display("[TB] FAIL t5_after got valid=%b tmo=%b want 0/1", obs_s_valid, obs_tmo); end
    endtask

    task automatic test_reset_mid_gnt();
        reset_dut(); use_rr = 1'b0;
        i_m1_valid = 1'b1; i_m1_addr = 64'h3000; i_s_rdata = 64'hAB;
        @(posedge i_clk); #4;
        n_cmp++; if (obs_busy !== 1'b1 || obs_owner !== 1'b1) begin n_bad++; $display("[TB] FAIL t6_gnt1 got busy=%b owner=%b want 1/1", obs_busy, obs_owner); end
        @(posedge i_clk); #2;
        i_rst = 1'b1; i_m1_valid = 1'b0; #2;
        n_cmp++; if (obs_m1_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL t6_no_pulse got %b want 0", obs_m1_ready); end
        @(posedge i_clk); #2;
        i_rst = 1'b0; i_s_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_cmp++; if ({obs_s_valid, obs_busy, obs_owner} !== 3'b000) begin n_bad++; $display("[TB] FAIL t6_idle%0d got %b%b%b want 000", k, obs_s_valid, obs_busy, obs_owner); end
            n_cmp++; if ({obs_m0_ready, obs_m1_ready} !== 2'b00) begin n_bad++; $display("[TB] FAIL t6_spurious%0d got %b%b want 00", k, obs_m0_ready, obs_m1_ready); end
            n_cmp++; if ((obs_m0_rdata | obs_m1_rdata | obs_s_addr) !== 64'h0) begin n_bad++; $display("[TB] FAIL t6_zero%0d got %h %h %h want 0", k, obs_m0_rdata, obs_m1_rdata, obs_s_addr); end
            @(posedge i_clk); #2;
        end
        i_s_ready = 1'b0;
    endtask

    initial begin
        $display("[TB] uni_arbiter bench start");
        test_reset();
        test_m0_read();
        test_priority();
        test_round_robin();
        test_m1_write();
        test_timeout();
        test_reset_mid_gnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
